// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter: FSM states,
// client slot assignments and the default burst limit before preemption.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    SWITCH = 2'd2
  } arb_state_t;

  localparam int CLI_VGA  = 0;
  localparam int CLI_DFJK = 1;
  localparam int CLI_NOTE = 2;

  localparam int MAX_BURST_DEF = 32;

endpackage

// File: rtl/sdram_port_arbiter_rr_picker.sv
// Combinational winner selection: the display client always wins when it
// requests; the remaining clients rotate starting just after rr_ptr.
module rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 3
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [1:0]             rr_ptr,
  output logic [1:0]             winner,
  output logic                   any_req
);

  logic found;

  always_comb begin
    winner = 2'(CLI_VGA);
    found  = 1'b0;
    for (int i = CLI_DFJK; i < NUM_CLIENTS; i++) begin
      if (!found && req[i] && (i > int'(rr_ptr))) begin
        winner = 2'(i);
        found  = 1'b1;
      end
    end
    // Wrap around to the lowest-numbered non-display client.
    for (int i = CLI_DFJK; i < NUM_CLIENTS; i++) begin
      if (!found && req[i]) begin
        winner = 2'(i);
        found  = 1'b1;
      end
    end
    if (req[CLI_VGA]) winner = 2'(CLI_VGA);
  end

  assign any_req = |req;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port among several copy/fetch engines with
// transaction-atomic grants, display priority and a burst preemption limit.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 128,
  parameter int MAX_BURST   = MAX_BURST_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        cli_req,
  input  logic [NUM_CLIENTS-1:0]        cli_rd,
  input  logic [NUM_CLIENTS-1:0]        cli_wr,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_wrdata,
  output logic [NUM_CLIENTS-1:0]        cli_wait,
  output logic [NUM_CLIENTS-1:0]        cli_ac,
  output logic [DATA_W-1:0]             cli_rddata,
  output logic                          mem_rd,
  output logic                          mem_wr,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wrdata,
  input  logic                          mem_wait,
  input  logic                          mem_ac,
  input  logic [DATA_W-1:0]             mem_rddata,
  output logic                          grant_valid,
  output logic [1:0]                    grant_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] burst_cnt;
  logic [1:0]       winner;
  logic             any_req;

  logic              own_req, own_rd, own_wr, others_req;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wrdata;
  logic              busy, boundary, burst_hit, release_own;

  rr_picker #(.NUM_CLIENTS(NUM_CLIENTS)) u_picker (
    .req     (cli_req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    own_req    = 1'b0;
    own_rd     = 1'b0;
    own_wr     = 1'b0;
    own_addr   = '0;
    own_wrdata = '0;
    others_req = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant_id == 2'(i)) begin
        own_req    = cli_req[i];
        own_rd     = cli_rd[i];
        own_wr     = cli_wr[i];
        own_addr   = cli_addr[i*ADDR_W +: ADDR_W];
        own_wrdata = cli_wrdata[i*DATA_W +: DATA_W];
      end else if (cli_req[i]) begin
        others_req = 1'b1;
      end
    end
  end

  // Owner signals pass straight through; grant_valid gates everything so an
  // asynchronous reset silences the controller port at once.
  always_comb begin
    mem_rd     = grant_valid & own_rd;
    mem_wr     = grant_valid & own_wr;
    mem_addr   = grant_valid ? own_addr : '0;
    mem_wrdata = grant_valid ? own_wrdata : '0;
    cli_wait   = '1;
    cli_ac     = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant_valid && grant_id == 2'(i)) begin
        cli_wait[i] = mem_wait;
        cli_ac[i]   = mem_ac;
      end
    end
  end

  assign cli_rddata = mem_rddata;

  // The ac that reaches the limit already counts, so the owner is cut off
  // on that same transaction boundary rather than one transaction later.
  assign busy        = own_rd | own_wr;
  assign boundary    = ~busy | mem_ac;
  assign burst_hit   = (burst_cnt == CNT_W'(MAX_BURST)) ||
                       (mem_ac && burst_cnt == CNT_W'(MAX_BURST - 1));
  assign release_own = (~own_req & ~busy) |
                       (burst_hit & others_req & boundary) |
                       (cli_req[CLI_VGA] & (grant_id != 2'(CLI_VGA)) & boundary);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= 2'd0;
      rr_ptr      <= 2'd0;
      burst_cnt   <= '0;
    end else begin
      case (state)
        IDLE, SWITCH: begin
          if (any_req) begin
            state       <= OWN;
            grant_valid <= 1'b1;
            grant_id    <= winner;
            burst_cnt   <= '0;
            if (winner != 2'(CLI_VGA)) rr_ptr <= winner;
          end else begin
            state <= IDLE;
          end
        end
        OWN: begin
          if (mem_ac && burst_cnt != CNT_W'(MAX_BURST))
            burst_cnt <= burst_cnt + CNT_W'(1);
          if (release_own) begin
            state       <= SWITCH;
            grant_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: cycle tables of client/controller activity with
// the expected grant owner per cycle, checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 22;
  localparam int DW = 128;
  localparam int MB = 4;

  localparam logic [2:0] VGA  = 3'(1 << CLI_VGA);
  localparam logic [2:0] DFJK = 3'(1 << CLI_DFJK);
  localparam logic [2:0] NOTE = 3'(1 << CLI_NOTE);
  localparam logic [2:0] ALL  = 3'b111;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  cli_req, cli_rd, cli_wr, cli_wait, cli_ac;
  logic [N*AW-1:0] cli_addr;
  logic [N*DW-1:0] cli_wrdata;
  logic [DW-1:0] cli_rddata, mem_wrdata, mem_rddata;
  logic          mem_rd, mem_wr, mem_wait, mem_ac, grant_valid;
  logic [AW-1:0] mem_addr;
  logic [1:0]    grant_id;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .cli_req(cli_req), .cli_rd(cli_rd), .cli_wr(cli_wr),
    .cli_addr(cli_addr), .cli_wrdata(cli_wrdata),
    .cli_wait(cli_wait), .cli_ac(cli_ac), .cli_rddata(cli_rddata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wrdata(mem_wrdata),
    .mem_wait(mem_wait), .mem_ac(mem_ac), .mem_rddata(mem_rddata),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  typedef struct {
    logic [2:0]    req, rd, wr;
    logic          mw, ma;
    logic          gv;
    logic [1:0]    gid;
    logic [DW-1:0] rdd;
  } vec_t;

  vec_t          vecs[$];
  vec_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            ac_count;
  logic [AW-1:0] addr_tab[N];
  logic [DW-1:0] wd_tab[N];

  function automatic vec_t mk(input logic [2:0] req, input logic [2:0] rd, input logic [2:0] wr,
                              input logic mw, input logic ma, input logic gv, input logic [1:0] gid);
    vec_t v;
    v.req = req; v.rd = rd; v.wr = wr; v.mw = mw; v.ma = ma;
    v.gv = gv; v.gid = gid; v.rdd = '0;
    return v;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h", nm, act, exp);
    end
  endtask

  task automatic compare(input vec_t e, input string nm);
    logic [2:0]    ew, ea;
    logic          erd, ewr;
    logic [AW-1:0] ead;
    logic [DW-1:0] ewd;
    ew = '1; ea = '0; erd = 1'b0; ewr = 1'b0; ead = '0; ewd = '0;
    if (e.gv) begin
      ew[e.gid] = e.mw;
      ea[e.gid] = e.ma;
      erd = e.rd[e.gid];
      ewr = e.wr[e.gid];
      ead = addr_tab[e.gid];
      ewd = wd_tab[e.gid];
    end
    check({nm, " grant_valid"}, DW'(grant_valid), DW'(e.gv));
    if (e.gv) check({nm, " grant_id"}, DW'(grant_id), DW'(e.gid));
    check({nm, " cli_wait"}, DW'(cli_wait), DW'(ew));
    check({nm, " cli_ac"}, DW'(cli_ac), DW'(ea));
    check({nm, " mem_rd"}, DW'(mem_rd), DW'(erd));
    check({nm, " mem_wr"}, DW'(mem_wr), DW'(ewr));
    check({nm, " mem_addr"}, DW'(mem_addr), DW'(ead));
    check({nm, " mem_wrdata"}, mem_wrdata, ewd);
    check({nm, " cli_rddata"}, cli_rddata, e.rdd);
  endtask

  task automatic apply(input vec_t v, input string nm);
    vec_t e;
    @(posedge clk); #1;
    cli_req  = v.req;
    cli_rd   = v.rd;
    cli_wr   = v.wr;
    mem_wait = v.mw;
    mem_ac   = v.ma;
    v.rdd    = {$urandom, $urandom, $urandom, $urandom};
    mem_rddata = v.rdd;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    compare(e, nm);
    if (cli_ac[CLI_DFJK]) ac_count++;
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[i]) apply(vecs[i], $sformatf("%s[%0d]", tag, i));
    vecs.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    cli_req = '0; cli_rd = '0; cli_wr = '0; mem_wait = 1'b0; mem_ac = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cli_req = '0; cli_rd = '0; cli_wr = '0;
    mem_wait = 1'b0; mem_ac = 1'b0; mem_rddata = '0;
    for (int i = 0; i < N; i++) begin
      addr_tab[i] = AW'(32'h10000 * (i + 1) + 32'h123 * i + 1);
      wd_tab[i]   = {4{32'hA5A5_0000 + 32'(i)}};
      cli_addr[i*AW +: AW]   = addr_tab[i];
      cli_wrdata[i*DW +: DW] = wd_tab[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset grant_valid", DW'(grant_valid), '0);
    check("reset grant_id", DW'(grant_id), '0);
    check("reset cli_wait", DW'(cli_wait), DW'(3'b111));
    check("reset cli_ac", DW'(cli_ac), '0);
    check("reset mem_rd", DW'(mem_rd), '0);
    check("reset mem_wr", DW'(mem_wr), '0);
    check("reset mem_addr", DW'(mem_addr), '0);
    check("reset mem_wrdata", mem_wrdata, '0);
    @(posedge clk); #1 reset = 1'b0;

    // Single client streaming 16 rd/wr pairs.
    ac_count = 0;
    vecs.push_back(mk(DFJK, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 32; k++)
      vecs.push_back(mk(DFJK, (k % 2 == 0) ? DFJK : 3'b000, (k % 2 == 1) ? DFJK : 3'b000, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    run_table("single");
    check("single ac pulses", DW'(ac_count), DW'(32));

    // Clients 1 and 2 together, then round-robin after re-request.
    do_reset();
    vecs.push_back(mk(DFJK | NOTE, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(DFJK | NOTE, DFJK, 0, 0, 1, 1, 1));
    vecs.push_back(mk(NOTE, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(NOTE, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(NOTE, NOTE, 0, 0, 1, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2));
    vecs.push_back(mk(DFJK | NOTE, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(NOTE, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(NOTE, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    run_table("rr");

    // Display requests while client 2 has a read outstanding.
    do_reset();
    vecs.push_back(mk(NOTE, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(NOTE, NOTE, 0, 1, 0, 1, 2));
    vecs.push_back(mk(NOTE | VGA, NOTE, 0, 1, 0, 1, 2));
    vecs.push_back(mk(NOTE | VGA, NOTE, 0, 0, 1, 1, 2));
    vecs.push_back(mk(NOTE | VGA, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(NOTE | VGA, 0, VGA, 0, 1, 1, 0));
    vecs.push_back(mk(NOTE, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(NOTE, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    run_table("vga_preempt");

    // Burst limit preemption of a streaming client.
    do_reset();
    vecs.push_back(mk(DFJK, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(DFJK, DFJK, 0, 0, 1, 1, 1));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(DFJK | NOTE, DFJK, 0, 0, 1, 1, 1));
    vecs.push_back(mk(DFJK | NOTE, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(DFJK | NOTE, NOTE, 0, 0, 1, 1, 2));
    vecs.push_back(mk(DFJK, 0, 0, 0, 0, 1, 2));
    vecs.push_back(mk(DFJK, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(DFJK, DFJK, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    run_table("burst");

    // Controller stalls for 10 cycles while everyone else requests.
    do_reset();
    vecs.push_back(mk(DFJK, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(DFJK, DFJK, 0, 1, 0, 1, 1));
    for (int k = 0; k < 9; k++) vecs.push_back(mk(ALL, DFJK, 0, 1, 0, 1, 1));
    vecs.push_back(mk(ALL, DFJK, 0, 0, 1, 1, 1));
    vecs.push_back(mk(ALL, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(DFJK | NOTE, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(DFJK | NOTE, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    run_table("stall");

    // Asynchronous reset with a read on the controller port.
    do_reset();
    apply(mk(DFJK, 0, 0, 1, 0, 0, 0), "areset pre0");
    apply(mk(DFJK, DFJK, 0, 1, 0, 1, 1), "areset pre1");
    #1 reset = 1'b1;
    #1;
    check("areset mem_rd", DW'(mem_rd), '0);
    check("areset grant_valid", DW'(grant_valid), '0);
    check("areset cli_wait", DW'(cli_wait), DW'(3'b111));
    check("areset mem_addr", DW'(mem_addr), '0);
    cli_req = '0; cli_rd = '0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post reset grant_valid", DW'(grant_valid), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single SDRAM controller port between up to NUM_CLIENTS copy/fetch engines: the VGA line fetcher, the DFJK lane-background copier and the note-sprite drawer. Each client keeps its existing rd/wr/addr/wrdata plus wait/ac handshake and sees a private, stall-capable port. The arbiter sits between the clients and the SDRAM controller. It guarantees transaction-atomic grants, fixed top priority for client 0 (display) and round-robin among the others.

## Interface
- NUM_CLIENTS, 3, number of requesters (2..4); client 0 is display and has fixed top priority
- ADDR_W, 22, SDRAM word-address width
- DATA_W, 128, SDRAM data width
- MAX_BURST, 32, accepted transactions (ac pulses) after which an owner is preempted if another client requests
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cli_req  in  NUM_CLIENTS  client wants the port; level, held until the client is done
- cli_rd, cli_wr  in  NUM_CLIENTS each  per-client read/write strobe; held until that client's ac
- cli_addr  in  NUM_CLIENTS×ADDR_W  per-client address
- cli_wrdata  in  NUM_CLIENTS×DATA_W  per-client write data
- cli_wait  out  NUM_CLIENTS  high = client must not start a transaction
- cli_ac  out  NUM_CLIENTS  per-client accept pulse
- cli_rddata  out  DATA_W  broadcast read data (mem_rddata passthrough)
- mem_rd, mem_wr  out  1 each  to SDRAM controller
- mem_addr  out  ADDR_W  to SDRAM controller
- mem_wrdata  out  DATA_W  to SDRAM controller
- mem_wait  in  1  controller not ready
- mem_ac  in  1  controller accepted current transaction
- mem_rddata  in  DATA_W  controller read data
- grant_valid  out  1  a client owns the port
- grant_id  out  2  current owner index

## Operation
- States: IDLE, OWN, SWITCH.
- IDLE: no owner; mem_rd/mem_wr = 0; every cli_wait = 1. If any cli_req is set, pick a winner and go to OWN next cycle.
- Pick rule: client 0 wins if it requests. Otherwise choose round-robin among clients 1..N-1, starting after rr_ptr. rr_ptr updates to the winner whenever the winner is ≠0.
- OWN: mem_rd/mem_wr/mem_addr/mem_wrdata mirror the owner's signals combinationally.
  - cli_wait[owner] = mem_wait; cli_ac[owner] = mem_ac.
  - All non-owners get wait = 1 and ac = 0.
- burst_cnt counts owner mem_ac pulses. It saturates at MAX_BURST and clears on every grant.
- Leave OWN through SWITCH when either condition holds:
  - (a) cli_req[owner] = 0 and the owner's rd and wr are both 0;
  - (b) burst_cnt == MAX_BURST, another client requests, and the owner's rd/wr are 0 or mem_ac is high this cycle (transaction boundary).
- A client never loses the port while its rd or wr is high without an ac.
- Exception: client 0 requesting while a non-zero client owns the port takes effect at the next boundary, ignoring burst_cnt.
- SWITCH: exactly one dead cycle; mem_rd/mem_wr = 0 and all waits = 1. Then pick again. If requests remain, go to OWN with the new winner (the same client is allowed if it is the only requester); otherwise go to IDLE.
- Protocol violation (owner drops cli_req while rd/wr is still high): the grant is kept until rd/wr clear.
- mem_addr/mem_wrdata are 0 when there is no owner.

## Timing
- Reset values (asynchronous):
  - state IDLE, grant_valid 0, grant_id 0, rr_ptr 0, burst_cnt 0;
  - mem_rd/mem_wr 0, mem_addr 0, mem_wrdata 0;
  - cli_wait all 1, cli_ac all 0.
- Reset asserted mid-transaction drops mem_rd/mem_wr immediately. The SDRAM controller is reset by the same signal.
- Grant latency from IDLE: req at cycle t → grant_valid and cli_wait[i] = mem_wait at t+1.
- Handover: owner release at t → SWITCH at t+1 → new owner at t+2.
- Data path is combinational in OWN: zero added latency on rd/wr/addr/ac, with no registered copy.
- cli_rddata is valid in the same cycle as mem_rddata. Clients latch on their own ac, as today.
- burst_cnt width is clog2(MAX_BURST+1). It counts mem_ac only when grant_valid is set.

## Structure
- Package sdram_arb_pkg holds:
  - arb_state_t enum {IDLE, OWN, SWITCH};
  - client index constants CLI_VGA = 0, CLI_DFJK = 1, CLI_NOTE = 2;
  - the default MAX_BURST.
- One sub-module, rr_picker: combinational. Inputs are the req vector and rr_ptr; outputs are winner index and any_req. Client 0 gets fixed priority and the rest are round-robin.

## Test plan
- Single client 1 req with 16 rd/wr pairs, mem_wait = 0, one-cycle ac → 32 ac pulses forwarded; client 1 grant_valid at t+1; client 0 cli_wait stays 1.
- Clients 1 and 2 request together at reset exit → grant 1. On release, SWITCH for one cycle, then grant 2. Both re-request → grant 1 (rr_ptr = 2).
- Client 2 owns the port and client 0 asserts req mid-read before ac → client 2 keeps the port until ac, then SWITCH, then client 0 owns two cycles after the ac.
- MAX_BURST = 4, client 1 streams continuously and client 2 requests → after the 4th ac, client 1 wait = 1 and client 2 is granted two cycles later. Client 1 is regranted after client 2 releases.
- mem_wait held high 10 cycles during OWN → owner wait is high and no ac occurs. The grant is not lost even with other requesters.
- Reset asserted while mem_rd = 1 → mem_rd = 0, grant_valid = 0, all cli_wait = 1 at the same edge.
